// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame-buffer arbiter between scan-out reads and a pixel writer,
// with a two-stage pixel pipeline that keeps colour and sync aligned.
module fb_arbiter #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int SCALE_SHIFT = 2,
  parameter bit BLANK_WR_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_tick,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        ledOn,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [11:0] wr_data,
  output logic        wr_ack,
  output logic        wr_oob,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        h_sync,
  output logic        v_sync
);
  localparam logic [14:0] W15 = 15'(FB_W);
  localparam logic [14:0] H15 = 15'(FB_H);
  localparam logic [14:0] SZ15 = 15'(FB_W * FB_H);
  logic [14:0] bx, by, disp_addr;
  logic disp, wr_gnt, ack_q, vid_act, s1_v, s1_disp, s1_hs, s1_vs;
  // Grant is combinational so the ack lands in the same cycle; reset masks it.
  always_comb begin
    bx = 15'(pix_x >> SCALE_SHIFT);
    by = 15'(pix_y >> SCALE_SHIFT);
    disp = pix_tick && ledOn && bx < W15 && by < H15;
    disp_addr = by * W15 + bx;
    wr_gnt = !reset && !disp && wr_req && !ack_q && (!BLANK_WR_ONLY || !vid_act);
    wr_ack = wr_gnt;
    mem_we = wr_gnt && wr_addr < SZ15;
    mem_addr = disp ? disp_addr : wr_addr;
    mem_wdata = wr_data;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ack_q <= 1'b0;
      wr_oob <= 1'b0;
      vid_act <= 1'b0;
      s1_v <= 1'b0;
      s1_disp <= 1'b0;
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
      {vga_r, vga_g, vga_b} <= 12'h0;
      h_sync <= 1'b1;
      v_sync <= 1'b1;
    end else begin
      ack_q <= wr_gnt;
      if (wr_gnt && wr_addr >= SZ15) wr_oob <= 1'b1;
      s1_v <= pix_tick;
      if (pix_tick) begin
        vid_act <= ledOn;
        s1_disp <= disp;
        s1_hs <= h_sync_in;
        s1_vs <= v_sync_in;
      end
      if (s1_v) begin
        {vga_r, vga_g, vga_b} <= s1_disp ? mem_rdata : 12'h0;
        h_sync <= s1_hs;
        v_sync <= s1_vs;
      end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: table-driven pixel vectors with a colour/sync scoreboard, plus writer,
// tear-free and reset corner sequences.
module tb_fb_arbiter;
  logic clk = 1'b0, reset = 1'b1, pix_tick = 1'b0, ledOn = 1'b0, h_sync_in = 1'b1, v_sync_in = 1'b1;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic wr_req = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [11:0] wr_data = '0, mem_rdata = '0, mem_wdata;
  logic wr_ack, wr_oob, mem_we, h_sync, v_sync;
  logic [14:0] mem_addr;
  logic [3:0] vga_r, vga_g, vga_b;
  logic b_wr_ack, b_wr_oob, b_mem_we, b_h_sync, b_v_sync;
  logic [14:0] b_mem_addr;
  logic [11:0] b_mem_wdata;
  logic [3:0] b_vga_r, b_vga_g, b_vga_b;
  logic [11:0] mem [0:32767];
  logic p1, p2, seen;
  int vec_cnt = 0, err_cnt = 0;

  typedef struct {
    logic [9:0] x, y;
    logic led, hs, vs, disp;
    logic [14:0] addr;
    logic [11:0] col;
  } vec_t;
  typedef struct {
    logic [11:0] col;
    logic hs, vs;
  } exp_t;
  vec_t vt[8];
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  fb_arbiter u_dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .pix_x(pix_x), .pix_y(pix_y), .ledOn(ledOn),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_oob(wr_oob), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .h_sync(h_sync), .v_sync(v_sync)
  );

  fb_arbiter #(.BLANK_WR_ONLY(1'b1)) u_blank (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .pix_x(pix_x), .pix_y(pix_y), .ledOn(ledOn),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(b_wr_ack), .wr_oob(b_wr_oob), .mem_addr(b_mem_addr),
    .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .vga_r(b_vga_r),
    .vga_g(b_vga_g), .vga_b(b_vga_b), .h_sync(b_h_sync), .v_sync(b_v_sync)
  );

  function automatic logic [11:0] pat(input int a);
    return 12'(a * 13 + 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_tick(input logic [9:0] x, input logic [9:0] y, input logic l,
                            input logic h, input logic v);
    pix_tick = 1'b1;
    pix_x = x;
    pix_y = y;
    ledOn = l;
    h_sync_in = h;
    v_sync_in = v;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk or posedge reset)
    if (reset) {p1, p2} <= 2'b00;
    else begin
      p1 <= pix_tick;
      p2 <= p1;
    end

  always @(negedge clk)
    if (p2) begin
      if (sb.size() == 0) chk("sb_unexpected_pixel", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("vga_colour", {vga_r, vga_g, vga_b}, e.col);
        chk("h_sync", h_sync, e.hs);
        chk("v_sync", v_sync, e.vs);
      end
    end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = pat(i);
    mem[162] = 12'hF0A;
    vt[0] = '{10'd8,   10'd4,   1'b1, 1'b1, 1'b1, 1'b1, 15'd162,   12'hF0A};
    vt[1] = '{10'd700, 10'd4,   1'b1, 1'b0, 1'b1, 1'b0, 15'd0,     12'h000};
    vt[2] = '{10'd0,   10'd0,   1'b1, 1'b1, 1'b0, 1'b1, 15'd0,     pat(0)};
    vt[3] = '{10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 1'b1, 15'd19199, pat(19199)};
    vt[4] = '{10'd640, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0, 15'd0,     12'h000};
    vt[5] = '{10'd0,   10'd480, 1'b1, 1'b1, 1'b1, 1'b0, 15'd0,     12'h000};
    vt[6] = '{10'd100, 10'd100, 1'b0, 1'b1, 1'b0, 1'b0, 15'd0,     12'h000};
    vt[7] = '{10'd4,   10'd8,   1'b1, 1'b1, 1'b1, 1'b1, 15'd321,   pat(321)};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vga", {vga_r, vga_g, vga_b}, 12'h0);
    chk("rst_h_sync", h_sync, 1'b1);
    chk("rst_v_sync", v_sync, 1'b1);
    chk("rst_wr_oob", wr_oob, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    foreach (vt[i]) begin
      cyc();
      drive_tick(vt[i].x, vt[i].y, vt[i].led, vt[i].hs, vt[i].vs);
      sb.push_back('{vt[i].col, vt[i].hs, vt[i].vs});
      @(negedge clk);
      if (vt[i].disp) chk("disp_addr", mem_addr, vt[i].addr);
      chk("disp_no_we", mem_we, 1'b0);
      cyc();
      pix_tick = 1'b0;
      repeat (3) cyc();
    end
    // writer collides with a display tick, then back-to-back spacing
    cyc();
    wr_req = 1'b1;
    wr_addr = 15'd5;
    wr_data = 12'h123;
    drive_tick(10'd8, 10'd4, 1'b1, 1'b1, 1'b1);
    sb.push_back('{12'hF0A, 1'b1, 1'b1});
    @(negedge clk);
    chk("collide_ack", wr_ack, 1'b0);
    chk("collide_we", mem_we, 1'b0);
    chk("collide_addr", mem_addr, 15'd162);
    cyc();
    pix_tick = 1'b0;
    @(negedge clk);
    chk("wr_ack", wr_ack, 1'b1);
    chk("wr_we", mem_we, 1'b1);
    chk("wr_addr", mem_addr, 15'd5);
    chk("wr_data", mem_wdata, 12'h123);
    cyc();
    @(negedge clk);
    chk("b2b_no_ack", wr_ack, 1'b0);
    cyc();
    @(negedge clk);
    chk("b2b_reack", wr_ack, 1'b1);
    cyc();
    wr_req = 1'b0;
    repeat (4) cyc();
    // last in-range address is writable, first out-of-range one is discarded
    wr_req = 1'b1;
    wr_addr = 15'd19199;
    @(negedge clk);
    chk("edge_we", mem_we, 1'b1);
    cyc();
    wr_req = 1'b0;
    @(negedge clk);
    chk("edge_no_oob", wr_oob, 1'b0);
    cyc();
    wr_req = 1'b1;
    wr_addr = 15'd19200;
    wr_data = 12'hFFF;
    @(negedge clk);
    chk("oob_ack", wr_ack, 1'b1);
    chk("oob_we", mem_we, 1'b0);
    cyc();
    wr_req = 1'b0;
    wr_addr = 15'd0;
    @(negedge clk);
    chk("oob_set", wr_oob, 1'b1);
    repeat (5) cyc();
    @(negedge clk);
    chk("oob_sticky", wr_oob, 1'b1);
    // tear-free instance: no writes while the last tick was active
    cyc();
    drive_tick(10'd8, 10'd4, 1'b1, 1'b1, 1'b1);
    sb.push_back('{12'hF0A, 1'b1, 1'b1});
    cyc();
    pix_tick = 1'b0;
    wr_req = 1'b1;
    wr_addr = 15'd10;
    wr_data = 12'h456;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("blank_hold_ack", b_wr_ack, 1'b0);
      chk("blank_hold_we", b_mem_we, 1'b0);
      cyc();
    end
    drive_tick(10'd8, 10'd4, 1'b0, 1'b1, 1'b1);
    sb.push_back('{12'h000, 1'b1, 1'b1});
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (b_wr_ack) seen = 1'b1;
      cyc();
      pix_tick = 1'b0;
    end
    chk("blank_ack_after_inactive", seen, 1'b1);
    wr_req = 1'b0;
    repeat (4) cyc();
    // reset lands between a tick and its output
    drive_tick(10'd8, 10'd4, 1'b1, 1'b0, 1'b1);
    sb.push_back('{12'hF0A, 1'b0, 1'b1});
    cyc();
    pix_tick = 1'b0;
    repeat (4) cyc();
    drive_tick(10'd8, 10'd4, 1'b1, 1'b1, 1'b0);
    cyc();
    pix_tick = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_vga", {vga_r, vga_g, vga_b}, 12'h0);
    chk("async_rst_h_sync", h_sync, 1'b1);
    chk("async_rst_oob", wr_oob, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_vga", {vga_r, vga_g, vga_b}, 12'h0);
      chk("post_rst_v_sync", v_sync, 1'b1);
    end
    repeat (3) cyc();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter FB_W, 160, frame-buffer width in stored pixels.
REQ-002 Parameter FB_H, 120, frame-buffer height in stored pixels.
REQ-003 Parameter SCALE_SHIFT, 2, screen-to-buffer downscale (screen coordinate >> SCALE_SHIFT).
REQ-004 Parameter BLANK_WR_ONLY, 0, when 1 writer is granted only while video is inactive (tear-free mode).
REQ-005 clk  input  1  system clock; the single clock for all logic.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 pix_tick  input  1  one-cycle strobe marking a new screen pixel.
REQ-008 pix_x, pix_y  input  10 each  screen coordinate, valid when pix_tick=1.
REQ-009 ledOn  input  1  video-active flag, valid when pix_tick=1.
REQ-010 h_sync_in, v_sync_in  input  1 each  sync from timing generator, sampled when pix_tick=1.
REQ-011 wr_req  input  1  writer request; held with wr_addr/wr_data stable until wr_ack.
REQ-012 wr_addr  input  15  linear buffer address; wr_data  input  12  {r,g,b} 4 bits each.
REQ-013 wr_ack  output  1  one-cycle pulse: write accepted.
REQ-014 wr_oob  output  1  sticky flag: a write with wr_addr >= FB_W*FB_H was accepted and discarded.
REQ-015 mem_addr  output  15; mem_we  output  1; mem_wdata  output  12; mem_rdata  input  12 (read latency exactly 1 clk).
REQ-016 vga_r, vga_g, vga_b  output  4 each  registered pixel colour.
REQ-017 h_sync, v_sync  output  1 each  sync delayed to align with colour.

Function
REQ-018 Memory port is single: each cycle exactly one of DISP (read), WR (write), NONE is granted.
REQ-019 DISP granted in a cycle with pix_tick=1, ledOn=1, (pix_x>>SCALE_SHIFT)<FB_W and (pix_y>>SCALE_SHIFT)<FB_H; DISP always wins over WR.
REQ-020 DISP address = (pix_y>>SCALE_SHIFT)*FB_W + (pix_x>>SCALE_SHIFT), computed in 15 bits, no truncation for default parameters (max 19199).
REQ-021 WR granted in any cycle where DISP is not granted, wr_req=1, wr_ack was 0 in the previous cycle, and (BLANK_WR_ONLY=0 or latched video-active=0).
REQ-022 On WR grant: mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1 same cycle; mem_we=1 only if wr_addr < FB_W*FB_H, else mem_we=0 and wr_oob set.
REQ-023 mem_we=0 in every non-WR cycle; mem_addr/mem_wdata don't-care then.
REQ-024 Writer back-to-back: wr_ack never asserts in two consecutive cycles; a held request is re-granted no earlier than 2 cycles after the previous ack.
REQ-025 Pixel pipeline: stage 1 (tick cycle) latches ledOn, in-range, syncs; stage 2 (tick+1) mem_rdata valid; colour/sync outputs update at tick+2 rising edge.
REQ-026 Colour output = mem_rdata when stage-1 pixel was DISP-granted; 0 when ledOn=0 or coordinate out of buffer range (border).
REQ-027 h_sync/v_sync outputs equal h_sync_in/v_sync_in sampled at tick, emitted at tick+2, so sync and colour remain aligned.
REQ-028 Outputs hold value between pixel updates; pix_tick spacing of 1 clock is legal (writer then starves during active video; no error).
REQ-029 Latched video-active for REQ-021 = ledOn sampled at last pix_tick.

Reset
REQ-030 While reset=1 (asynchronously): vga_r/g/b=0, h_sync=v_sync=1, wr_ack=0, mem_we=0, wr_oob=0, pipeline valid bits=0, latched video-active=0.
REQ-031 Reset mid-write or mid-pixel aborts the operation; no pending write or read completes after deassertion.
REQ-032 First pixel output after reset occurs at the second rising edge following the first pix_tick.

Verification
REQ-033 pix_tick every 4 clks, x=8,y=4 active, mem_rdata=12'hF0A -> mem_addr=162 at tick, vga={F,0,A} at tick+2.
REQ-034 wr_req held, wr_addr=5, wr_data=12'h123, BLANK_WR_ONLY=0, tick coincides -> wr_ack delayed one cycle, then mem_we=1 addr 5 data 123.
REQ-035 BLANK_WR_ONLY=1, ledOn=1 -> no wr_ack; after tick with ledOn=0 -> wr_ack within 1 cycle.
REQ-036 wr_addr=19200 -> wr_ack=1, mem_we=0, wr_oob=1 and stays 1 until reset.
REQ-037 x=700 active (out of buffer) -> no read, colour 0; h_sync_in=0 at tick -> h_sync=0 at tick+2.
REQ-038 Assert reset between tick and tick+2 -> outputs reset values immediately, no colour update after release until next tick+2.
